// File: rtl/cpm_console.sv
// rtl/cpm_console.sv - 8080 CP/M console I/O port: TX FIFO, RX holding register, status port
// Optional RX path enabled by defining CPM_CONSOLE_RX_EN.

`ifndef STATUS_INP
`define STATUS_INP 6
`endif
`ifndef STATUS_OUT
`define STATUS_OUT 4
`endif

module cpm_console #(
    parameter int         XLEN        = 8,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] STATUS_PORT = 8'h00,
    parameter logic [7:0] DATA_PORT   = 8'h01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] status,
    input  logic [7:0]      io_addr,
    input  logic            dbin,
    input  logic            write_n,
    inout  wire  [XLEN-1:0] data,
    output logic [XLEN-1:0] tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [XLEN-1:0] rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic            overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [XLEN-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            write_n_q, dbin_q;
    // Edge history is only trusted one cycle after reset release, so a strobe
    // already asserted when reset lifts is not seen as a fresh edge.
    logic            hist_q;

    logic sel_out, sel_inp, hit_status, hit_data;
    logic wr_fall, rd_fall, push_req, push, pop, drop, full;
    logic rx_full_flag;
    logic [XLEN-1:0] data_rd, status_byte, rd_val;
    logic drive;
    logic unused_bits;

    assign sel_out    = status[`STATUS_OUT];
    assign sel_inp    = status[`STATUS_INP];
    assign hit_status = (io_addr == STATUS_PORT);
    assign hit_data   = (io_addr == DATA_PORT);

    assign wr_fall  = hist_q & write_n_q & ~write_n;
    assign rd_fall  = dbin_q & ~dbin;
    assign push_req = wr_fall & sel_out & hit_data;

    assign full     = (count_q == DEPTH_C);
    assign tx_valid = (count_q != '0);
    assign pop      = tx_valid & tx_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (rd_fall && sel_inp && hit_status) overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            write_n_q  <= 1'b1;
            dbin_q     <= 1'b0;
            hist_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            write_n_q  <= write_n;
            dbin_q     <= dbin;
            hist_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= data;
    end

`ifdef CPM_CONSOLE_RX_EN
    logic            rx_full_q, rx_full_d;
    logic [XLEN-1:0] rx_hold_q, rx_hold_d;

    always_comb begin
        rx_full_d = rx_full_q;
        rx_hold_d = rx_hold_q;
        if (rx_full_q) begin
            if (rd_fall && sel_inp && hit_data) rx_full_d = 1'b0;
        end else if (rx_valid) begin
            rx_full_d = 1'b1;
            rx_hold_d = rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_full_q <= 1'b0;
            rx_hold_q <= '0;
        end else begin
            rx_full_q <= rx_full_d;
            rx_hold_q <= rx_hold_d;
        end
    end

    assign rx_ready     = ~rx_full_q;
    assign rx_full_flag = rx_full_q;
    assign data_rd      = rx_hold_q;
`else
    // CP/M treats 0x1A as end-of-file, so a console with no input reads as EOF.
    assign rx_ready     = 1'b0;
    assign rx_full_flag = 1'b0;
    assign data_rd      = XLEN'(8'h1A);
`endif

    always_comb begin
        status_byte    = '0;
        status_byte[0] = rx_full_flag;
        status_byte[1] = ~full;
        status_byte[7] = overflow_q;
    end

    assign rd_val = hit_status ? status_byte : data_rd;
    assign drive  = dbin & sel_inp & (hit_status | hit_data);
    assign data   = drive ? rd_val : {XLEN{1'bz}};

    assign unused_bits = ^{status, rx_data, rx_valid};

endmodule

// File: tb/tb_cpm_console.sv
// tb/tb_cpm_console.sv - directed-vector bench for cpm_console (either RX build)

module tb_cpm_console;
    localparam logic [7:0] ST_OUT  = 8'h10;
    localparam logic [7:0] ST_INP  = 8'h40;
    localparam logic [7:0] ST_MEMR = 8'h80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] status, io_addr;
    logic       dbin, write_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       overflow;
    wire  [7:0] data_w;
    logic [7:0] tb_dout;
    logic       tb_oe;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] beat_q[$];

    assign data_w = tb_oe ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    cpm_console dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .status   (status),
        .io_addr  (io_addr),
        .dbin     (dbin),
        .write_n  (write_n),
        .data     (data_w),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overflow (overflow)
    );

    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) beat_q.push_back(tx_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic out_cycle(input logic [7:0] port, input logic [7:0] val, input int hold);
        status  = ST_OUT;
        io_addr = port;
        tb_dout = val;
        tb_oe   = 1'b1;
        write_n = 1'b0;
        repeat (hold) @(negedge clk);
        write_n = 1'b1;
        tb_oe   = 1'b0;
        status  = 8'h00;
        @(negedge clk);
    endtask

    task automatic in_cycle(input logic [7:0] port, output logic [7:0] val);
        status  = ST_INP;
        io_addr = port;
        dbin    = 1'b1;
        @(negedge clk);
        val  = data_w;
        dbin = 1'b0;
        @(negedge clk);
        status = 8'h00;
    endtask

    task automatic drain_tx(input int bound);
        tx_ready = 1'b1;
        for (int c = 0; c < bound && tx_valid; c++) @(negedge clk);
        check_eq("drain_done", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int bad;

        rst_n = 1'b0; status = 8'h00; io_addr = 8'h00; dbin = 1'b0; write_n = 1'b1;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tb_dout = 8'h00; tb_oe = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
`ifdef CPM_CONSOLE_RX_EN
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
`else
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
`endif
        in_cycle(8'h00, v);
        check_eq("rst_status", {24'd0, v}, 32'h02);

        // Single OUT held low for three cycles gives exactly one beat
        beat_q.delete();
        tx_ready = 1'b1;
        out_cycle(8'h01, 8'h41, 3);
        repeat (2) @(negedge clk);
        check_eq("one_beat_count", beat_q.size(), 32'd1);
        if (beat_q.size() > 0) check_eq("one_beat_data", {24'd0, beat_q[0]}, 32'h41);
        check_eq("one_beat_idle", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // 17 OUTs into a 16-deep FIFO: last is dropped, overflow set
        for (int i = 0; i < 17; i++) out_cycle(8'h01, 8'(i), 1);
        check_eq("ovf_flag", {31'd0, overflow}, 32'd1);
        in_cycle(8'h00, v);
        check_eq("ovf_status", {24'd0, v}, 32'h80);
        check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);
        beat_q.delete();
        drain_tx(40);
        check_eq("ovf_drain_count", beat_q.size(), 32'd16);
        bad = 0;
        for (int i = 0; i < beat_q.size() && i < 16; i++) if (beat_q[i] !== 8'(i)) bad++;
        check_eq("ovf_drain_order", bad, 32'd0);
        in_cycle(8'h00, v);
        check_eq("ovf_status_after", {24'd0, v}, 32'h02);

        // Full FIFO with a push concurrent with a pop: push accepted
        beat_q.delete();
        for (int i = 0; i < 16; i++) out_cycle(8'h01, 8'h20 + 8'(i), 1);
        tx_ready = 1'b1; status = ST_OUT; io_addr = 8'h01; tb_dout = 8'h99; tb_oe = 1'b1; write_n = 1'b0;
        @(negedge clk);
        tx_ready = 1'b0; write_n = 1'b1; tb_oe = 1'b0; status = 8'h00;
        @(negedge clk);
        check_eq("pp_one_pop", beat_q.size(), 32'd1);
        check_eq("pp_no_ovf", {31'd0, overflow}, 32'd0);
        in_cycle(8'h00, v);
        check_eq("pp_status_full", {24'd0, v}, 32'h00);
        drain_tx(40);
        check_eq("pp_total", beat_q.size(), 32'd17);
        bad = 0;
        for (int i = 0; i < beat_q.size() && i < 16; i++) if (beat_q[i] !== 8'h20 + 8'(i)) bad++;
        check_eq("pp_order", bad, 32'd0);
        if (beat_q.size() == 17) check_eq("pp_last", {24'd0, beat_q[16]}, 32'h99);

`ifdef CPM_CONSOLE_RX_EN
        rx_data = 8'h55; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("rx_ready_low", {31'd0, rx_ready}, 32'd0);
        in_cycle(8'h00, v);
        check_eq("rx_status_full", {24'd0, v}, 32'h03);
        in_cycle(8'h01, v);
        check_eq("rx_data_read", {24'd0, v}, 32'h55);
        in_cycle(8'h00, v);
        check_eq("rx_status_empty", {24'd0, v}, 32'h02);
        check_eq("rx_ready_back", {31'd0, rx_ready}, 32'd1);
        in_cycle(8'h01, v);
        check_eq("rx_stale_read", {24'd0, v}, 32'h55);
        check_eq("rx_stale_ready", {31'd0, rx_ready}, 32'd1);
        rx_data = 8'h77; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
`else
        rx_data = 8'h55; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        in_cycle(8'h01, v);
        check_eq("eof_read", {24'd0, v}, 32'h1A);
        check_eq("eof_rx_ready", {31'd0, rx_ready}, 32'd0);
        in_cycle(8'h00, v);
        check_eq("eof_status", {24'd0, v}, 32'h02);
`endif

        // Memory read at a matching address: bus stays released, no side effects
        status = ST_MEMR; io_addr = 8'h01; dbin = 1'b1;
        @(negedge clk);
        check_eq("mem_bus_released", {31'd0, (data_w !== 8'hzz) && (data_w !== 8'h00)}, 32'd0);
        dbin = 1'b0;
        @(negedge clk);
        status = 8'h00;
        in_cycle(8'h00, v);
`ifdef CPM_CONSOLE_RX_EN
        check_eq("mem_no_effect", {24'd0, v}, 32'h03);
        in_cycle(8'h01, v);
        check_eq("mem_rx_kept", {24'd0, v}, 32'h77);
`else
        check_eq("mem_no_effect", {24'd0, v}, 32'h02);
`endif

        // Reset asserted mid-OUT with write_n still low at release
        for (int i = 0; i < 17; i++) out_cycle(8'h01, 8'hC0 + 8'(i), 1);
        check_eq("pre_rst_ovf", {31'd0, overflow}, 32'd1);
        status = ST_OUT; io_addr = 8'h01; tb_dout = 8'hEE; tb_oe = 1'b1; write_n = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        write_n = 1'b1; tb_oe = 1'b0; status = 8'h00;
        @(negedge clk);
        check_eq("rst_mid_empty", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_mid_ovf", {31'd0, overflow}, 32'd0);
        beat_q.delete();
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        check_eq("rst_mid_no_push", beat_q.size(), 32'd0);
        in_cycle(8'h00, v);
        check_eq("rst_mid_status", {24'd0, v}, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
